bp_dma_channel_arbiter: RTL and testbench
=========================================

// Module: bp_dma_channel_arbiter
// PURPOSE
//  Shares one off-chip DRAM DMA channel between num_dma_p L2 cache DMA ports of the unicore.
//  Requests are arbitrated round-robin; each write block is streamed from the winning port.
//  Read responses return in request order and are steered back to the requesting port
//  using an in-order tag FIFO. Sits between the chip's per-slice DMA interface and the DRAM link.
// PARAMETERS
//  num_dma_p         2    number of cache DMA ports (l2_dmas_p)
//  pkt_width_p       64   DMA packet width (dma_pkt_width_lp)
//  data_width_p      64   DMA data beat width (l2_fill_width_p)
//  block_beats_p     8    data beats per DMA block, >=1
//  max_reads_p       4    max outstanding reads (tag FIFO depth), >=1
//  write_bit_p       pkt_width_p-1   index of write_not_read bit in packet
// PORTS
//  clk_i                 in   1                     clock
//  reset_i               in   1                     synchronous active-high reset
//  dma_pkt_i             in   num_dma_p*pkt_width_p packet per port
//  dma_pkt_v_i           in   num_dma_p             packet valid per port
//  dma_pkt_ready_and_o   out  num_dma_p             packet accepted per port
//  dma_data_i            in   num_dma_p*data_width_p write data per port
//  dma_data_v_i          in   num_dma_p             write data valid
//  dma_data_ready_and_o  out  num_dma_p             write data accepted
//  dma_data_o            out  num_dma_p*data_width_p read data per port (broadcast)
//  dma_data_v_o          out  num_dma_p             read data valid
//  dma_data_ready_and_i  in   num_dma_p             read data accepted
//  mem_pkt_o / _v_o      out  pkt_width_p / 1       packet to DRAM
//  mem_pkt_ready_and_i   in   1
//  mem_data_o / _v_o     out  data_width_p / 1      write data to DRAM
//  mem_data_ready_and_i  in   1
//  mem_data_i / _v_i     in   data_width_p / 1      read data from DRAM
//  mem_data_ready_and_o  out  1
//  reads_pending_o       out  clog2(max_reads_p+1)  tag FIFO occupancy
// BEHAVIOUR
//  - Reset: state=IDLE, rr pointer=0, beat counters=0, FIFO empty. All *_v_o, *_ready_and_o = 0;
//    reads_pending_o = 0.
//  - Ready/valid handshakes throughout; a transfer occurs when v & ready_and are both high.
//    Valid never depends on ready.
//  - States: IDLE, WDATA.
//  - IDLE: port i is eligible if dma_pkt_v_i[i] and (the packet is a write, or the FIFO is not full).
//    Winner = first eligible port at or after rr pointer (wrapping).
//    mem_pkt_o = winner packet; mem_pkt_v_o = any eligible.
//    dma_pkt_ready_and_o[winner] = mem_pkt_ready_and_i; all other bits 0. Combinational, 0 latency.
//  - On packet handshake: rr pointer = winner+1 mod num_dma_p.
//    Read: push the winner id into the FIFO; stay IDLE.
//    Write: owner = winner, wcnt = 0, go to WDATA.
//  - WDATA: no packets granted (mem_pkt_v_o = 0).
//    mem_data_o = dma_data_i[owner]; mem_data_v_o = dma_data_v_i[owner].
//    dma_data_ready_and_o[owner] = mem_data_ready_and_i; other bits 0.
//    Each beat handshake increments wcnt. On beat block_beats_p-1, go to IDLE.
//    In IDLE, dma_data_ready_and_o = 0 and mem_data_v_o = 0.
//  - Read return, independent of state: head = FIFO head id.
//    dma_data_o[k] = mem_data_i for all k; dma_data_v_o[head] = mem_data_v_i & ~empty.
//    mem_data_ready_and_o = ~empty & dma_data_ready_and_i[head].
//    Each beat handshake increments rcnt. On beat block_beats_p-1: pop the FIFO, rcnt = 0.
//  - FIFO full is evaluated on the registered count. A push and a pop in the same cycle are legal;
//    there is no full bypass, so a read is not granted while full even if a pop occurs that cycle.
//  - Counter widths are clog2(block_beats_p) (min 1). A counter wraps to 0 only at its terminal beat.
//  - Return data with an empty FIFO is not accepted (ready_and stays 0). This is a protocol error,
//    not a drop.
//  - Reset mid-operation: all in-flight write/read tracking is discarded immediately.
//    No output glitches for the remainder of the reset cycle.
// TESTING
//  1. num_dma_p=2; both ports post reads continuously; mem always ready
//     -> grants alternate 0,1,0,1; reads_pending_o saturates at 4; a 5th read stalls until a pop.
//  2. Port 1 posts a write; its data arrives 3 cycles late
//     -> 8 beats pass through unchanged; a read from port 0 is not granted until after the 8th beat.
//  3. Reads issued in order 1,0,1; DRAM returns 24 beats
//     -> beats 0-7 go to port 1, 8-15 to port 0, 16-23 to port 1; pending goes 3->2->1->0.
//  4. Return to port 0 with dma_data_ready_and_i[0] toggling 1,0 -> mem_data_ready_and_o mirrors
//     the toggle; no beat is lost or duplicated.
//  5. A block pop and a new read grant in the same cycle at count 3 -> count stays 3; FIFO order
//     is preserved.
//  6. Assert reset_i mid-WDATA at beat 4 -> the next cycle is IDLE, all valids are 0, count is 0,
//     and the rr pointer is 0.

Source files
------------

// File: rtl/bp_dma_channel_arbiter.sv
// ---------------------------------------------------------------------------
// bp_dma_channel_arbiter
//
// Shares one DRAM DMA channel between num_dma_p L2 cache DMA ports.
// Packets are arbitrated round-robin. A granted write holds the channel and
// streams block_beats_p data beats from the owning port. A granted read pushes
// the requesting port id into an in-order tag FIFO. Returning read beats are
// broadcast to every port, and the valid bit is steered to the FIFO head.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   dma_pkt_*                 per-port request packets (ready/valid)
//   dma_data_i/_v_i/_ready_o  per-port write data toward DRAM
//   dma_data_o/_v_o/_ready_i  per-port read data from DRAM (data broadcast)
//   mem_pkt_*                 packet channel to DRAM
//   mem_data_o/_v_o/_ready_i  write data channel to DRAM
//   mem_data_i/_v_i/_ready_o  read data channel from DRAM
//   reads_pending_o           number of reads still awaiting their block
// ---------------------------------------------------------------------------
module bp_dma_channel_arbiter #(
    parameter int num_dma_p     = 2,
    parameter int pkt_width_p   = 64,
    parameter int data_width_p  = 64,
    parameter int block_beats_p = 8,
    parameter int max_reads_p   = 4,
    parameter int write_bit_p   = pkt_width_p - 1
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_dma_p*pkt_width_p-1:0]  dma_pkt_i,
    input  logic [num_dma_p-1:0]              dma_pkt_v_i,
    output logic [num_dma_p-1:0]              dma_pkt_ready_and_o,
    input  logic [num_dma_p*data_width_p-1:0] dma_data_i,
    input  logic [num_dma_p-1:0]              dma_data_v_i,
    output logic [num_dma_p-1:0]              dma_data_ready_and_o,
    output logic [num_dma_p*data_width_p-1:0] dma_data_o,
    output logic [num_dma_p-1:0]              dma_data_v_o,
    input  logic [num_dma_p-1:0]              dma_data_ready_and_i,
    output logic [pkt_width_p-1:0]            mem_pkt_o,
    output logic                              mem_pkt_v_o,
    input  logic                              mem_pkt_ready_and_i,
    output logic [data_width_p-1:0]           mem_data_o,
    output logic                              mem_data_v_o,
    input  logic                              mem_data_ready_and_i,
    input  logic [data_width_p-1:0]           mem_data_i,
    input  logic                              mem_data_v_i,
    output logic                              mem_data_ready_and_o,
    output logic [$clog2(max_reads_p+1)-1:0]  reads_pending_o
);

    localparam int id_w_lp  = (num_dma_p > 1) ? $clog2(num_dma_p) : 1;
    localparam int cnt_w_lp = (block_beats_p > 1) ? $clog2(block_beats_p) : 1;
    localparam int ptr_w_lp = (max_reads_p > 1) ? $clog2(max_reads_p) : 1;
    localparam int occ_w_lp = $clog2(max_reads_p + 1);

    localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(block_beats_p - 1);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp  = ptr_w_lp'(max_reads_p - 1);
    localparam logic [occ_w_lp-1:0] full_cnt_lp  = occ_w_lp'(max_reads_p);
    localparam logic [id_w_lp-1:0]  last_id_lp   = id_w_lp'(num_dma_p - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WDATA = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [id_w_lp-1:0]    rr_q, rr_d;
    logic [id_w_lp-1:0]    owner_q, owner_d;
    logic [cnt_w_lp-1:0]   wcnt_q, wcnt_d;
    logic [cnt_w_lp-1:0]   rcnt_q, rcnt_d;
    logic [ptr_w_lp-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0]   rd_ptr_q, rd_ptr_d;
    logic [occ_w_lp-1:0]   count_q, count_d;
    logic [id_w_lp-1:0]    fifo_mem_q [max_reads_p];
    logic [id_w_lp-1:0]    fifo_mem_d [max_reads_p];

    logic [num_dma_p-1:0]  is_wr_s;
    logic [num_dma_p-1:0]  eligible_s;
    logic                  any_elig_s;
    logic [id_w_lp-1:0]    winner_s;
    logic                  winner_wr_s;
    logic [id_w_lp-1:0]    idx_s;
    logic                  full_s;
    logic                  empty_s;
    logic [id_w_lp-1:0]    head_s;
    logic                  pkt_hs_s;
    logic                  wr_hs_s;
    logic                  rd_hs_s;
    logic                  push_s;
    logic                  pop_s;

    assign full_s  = (count_q == full_cnt_lp);
    assign empty_s = (count_q == '0);
    assign head_s  = fifo_mem_q[rd_ptr_q];

    // Round-robin search: first eligible port at or after the rr pointer.
    // Reads need a free tag slot; full is taken from the registered count only.
    always_comb begin
        is_wr_s     = '0;
        eligible_s  = '0;
        any_elig_s  = 1'b0;
        winner_s    = '0;
        winner_wr_s = 1'b0;
        idx_s       = '0;
        for (int i = 0; i < num_dma_p; i++) begin
            is_wr_s[i]    = dma_pkt_i[i*pkt_width_p + write_bit_p];
            eligible_s[i] = dma_pkt_v_i[i] & (is_wr_s[i] | ~full_s);
        end
        for (int off = 0; off < num_dma_p; off++) begin
            idx_s = id_w_lp'((int'(rr_q) + off) % num_dma_p);
            if (!any_elig_s && eligible_s[idx_s]) begin
                any_elig_s  = 1'b1;
                winner_s    = idx_s;
                winner_wr_s = is_wr_s[idx_s];
            end else begin
                any_elig_s  = any_elig_s;
            end
        end
    end

    // Output steering; every valid/ready is forced low while reset_i is high.
    always_comb begin
        mem_pkt_o            = '0;
        mem_data_o           = '0;
        mem_pkt_v_o          = 1'b0;
        mem_data_v_o         = 1'b0;
        dma_pkt_ready_and_o  = '0;
        dma_data_ready_and_o = '0;
        dma_data_v_o         = '0;
        dma_data_o           = {num_dma_p{mem_data_i}};
        mem_data_ready_and_o = 1'b0;
        for (int i = 0; i < num_dma_p; i++) begin
            if (winner_s == id_w_lp'(i)) begin
                mem_pkt_o = dma_pkt_i[i*pkt_width_p +: pkt_width_p];
            end else begin
                mem_pkt_o = mem_pkt_o;
            end
            if (owner_q == id_w_lp'(i)) begin
                mem_data_o = dma_data_i[i*data_width_p +: data_width_p];
            end else begin
                mem_data_o = mem_data_o;
            end
        end
        if (!reset_i) begin
            if (state_q == IDLE) begin
                mem_pkt_v_o = any_elig_s;
                dma_pkt_ready_and_o[winner_s] = any_elig_s & mem_pkt_ready_and_i;
            end else begin
                mem_data_v_o = dma_data_v_i[owner_q];
                dma_data_ready_and_o[owner_q] = mem_data_ready_and_i;
            end
            dma_data_v_o[head_s] = mem_data_v_i & ~empty_s;
            mem_data_ready_and_o = ~empty_s & dma_data_ready_and_i[head_s];
        end else begin
            mem_pkt_v_o = 1'b0;
        end
    end

    assign reads_pending_o = reset_i ? '0 : count_q;

    assign pkt_hs_s = mem_pkt_v_o & mem_pkt_ready_and_i;
    assign wr_hs_s  = mem_data_v_o & mem_data_ready_and_i;
    assign rd_hs_s  = mem_data_v_i & mem_data_ready_and_o;
    assign push_s   = pkt_hs_s & ~winner_wr_s;
    assign pop_s    = rd_hs_s & (rcnt_q == last_beat_lp);

    // Next-state: FSM, rr pointer, beat counters and tag FIFO bookkeeping.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        wcnt_d   = wcnt_q;
        rcnt_d   = rcnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int j = 0; j < max_reads_p; j++) begin
            fifo_mem_d[j] = fifo_mem_q[j];
        end

        if (pkt_hs_s) begin
            rr_d = (winner_s == last_id_lp) ? '0 : winner_s + id_w_lp'(1);
            if (winner_wr_s) begin
                owner_d = winner_s;
                wcnt_d  = '0;
                state_d = WDATA;
            end else begin
                fifo_mem_d[wr_ptr_q] = winner_s;
                wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + ptr_w_lp'(1);
            end
        end else begin
            rr_d = rr_q;
        end

        if (wr_hs_s) begin
            if (wcnt_q == last_beat_lp) begin
                wcnt_d  = '0;
                state_d = IDLE;
            end else begin
                wcnt_d = wcnt_q + cnt_w_lp'(1);
            end
        end else begin
            wcnt_d = wcnt_d;
        end

        if (rd_hs_s) begin
            if (rcnt_q == last_beat_lp) begin
                rcnt_d   = '0;
                rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + ptr_w_lp'(1);
            end else begin
                rcnt_d = rcnt_q + cnt_w_lp'(1);
            end
        end else begin
            rcnt_d = rcnt_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + occ_w_lp'(1);
            2'b01:   count_d = count_q - occ_w_lp'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards all in-flight write and read tracking.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            owner_q  <= '0;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int j = 0; j < max_reads_p; j++) begin
                fifo_mem_q[j] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int j = 0; j < max_reads_p; j++) begin
                fifo_mem_q[j] <= fifo_mem_d[j];
            end
        end
    end

endmodule

// File: tb/tb_bp_dma_channel_arbiter.sv
// ---------------------------------------------------------------------------
// Directed testbench for bp_dma_channel_arbiter (2 ports, 64-bit packets and
// data, 8-beat blocks, 4 outstanding reads). Inputs change 1 time unit after
// the rising edge; outputs are sampled 2 time units after the rising edge.
// ---------------------------------------------------------------------------
module tb_bp_dma_channel_arbiter;

    localparam logic [63:0] PKT_RD0 = 64'h0000_0000_1000_0000;
    localparam logic [63:0] PKT_RD1 = 64'h0000_0000_2000_0001;
    localparam logic [63:0] PKT_WR0 = 64'h8000_0000_3000_0000;
    localparam logic [63:0] PKT_WR1 = 64'h8000_0000_4000_0001;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [127:0] dma_pkt_i;
    logic [1:0]   dma_pkt_v_i;
    logic [1:0]   dma_pkt_ready_and_o;
    logic [127:0] dma_data_i;
    logic [1:0]   dma_data_v_i;
    logic [1:0]   dma_data_ready_and_o;
    logic [127:0] dma_data_o;
    logic [1:0]   dma_data_v_o;
    logic [1:0]   dma_data_ready_and_i;
    logic [63:0]  mem_pkt_o;
    logic         mem_pkt_v_o;
    logic         mem_pkt_ready_and_i;
    logic [63:0]  mem_data_o;
    logic         mem_data_v_o;
    logic         mem_data_ready_and_i;
    logic [63:0]  mem_data_i;
    logic         mem_data_v_i;
    logic         mem_data_ready_and_o;
    logic [2:0]   reads_pending_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    bp_dma_channel_arbiter dut (
        .clk_i                (clk),
        .reset_i              (reset_i),
        .dma_pkt_i            (dma_pkt_i),
        .dma_pkt_v_i          (dma_pkt_v_i),
        .dma_pkt_ready_and_o  (dma_pkt_ready_and_o),
        .dma_data_i           (dma_data_i),
        .dma_data_v_i         (dma_data_v_i),
        .dma_data_ready_and_o (dma_data_ready_and_o),
        .dma_data_o           (dma_data_o),
        .dma_data_v_o         (dma_data_v_o),
        .dma_data_ready_and_i (dma_data_ready_and_i),
        .mem_pkt_o            (mem_pkt_o),
        .mem_pkt_v_o          (mem_pkt_v_o),
        .mem_pkt_ready_and_i  (mem_pkt_ready_and_i),
        .mem_data_o           (mem_data_o),
        .mem_data_v_o         (mem_data_v_o),
        .mem_data_ready_and_i (mem_data_ready_and_i),
        .mem_data_i           (mem_data_i),
        .mem_data_v_i         (mem_data_v_i),
        .mem_data_ready_and_o (mem_data_ready_and_o),
        .reads_pending_o      (reads_pending_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dma_pkt_i            = '0;
        dma_pkt_v_i          = 2'b00;
        dma_data_i           = '0;
        dma_data_v_i         = 2'b00;
        dma_data_ready_and_i = 2'b11;
        mem_pkt_ready_and_i  = 1'b1;
        mem_data_ready_and_i = 1'b1;
        mem_data_i           = '0;
        mem_data_v_i         = 1'b0;
    endtask

    task automatic apply_reset();
        reset_i = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        clear_inputs();
        dma_pkt_i    = {PKT_RD1, PKT_RD0};
        dma_pkt_v_i  = 2'b11;
        dma_data_v_i = 2'b11;
        mem_data_v_i = 1'b1;
        tick();
        #1;
        total_cnt++; if (mem_pkt_v_o !== 1'b0) $display("FAIL reset_mem_pkt_v got %b want 0", mem_pkt_v_o); else pass_cnt++;
        total_cnt++; if (dma_pkt_ready_and_o !== 2'b00) $display("FAIL reset_pkt_ready got %b want 00", dma_pkt_ready_and_o); else pass_cnt++;
        total_cnt++; if (mem_data_v_o !== 1'b0) $display("FAIL reset_mem_data_v got %b want 0", mem_data_v_o); else pass_cnt++;
        total_cnt++; if (dma_data_ready_and_o !== 2'b00) $display("FAIL reset_data_ready got %b want 00", dma_data_ready_and_o); else pass_cnt++;
        total_cnt++; if (dma_data_v_o !== 2'b00) $display("FAIL reset_dma_data_v got %b want 00", dma_data_v_o); else pass_cnt++;
        total_cnt++; if (mem_data_ready_and_o !== 1'b0) $display("FAIL reset_mem_ready got %b want 0", mem_data_ready_and_o); else pass_cnt++;
        total_cnt++; if (reads_pending_o !== 3'd0) $display("FAIL reset_pending got %0d want 0", reads_pending_o); else pass_cnt++;
        reset_i = 1'b0;
        clear_inputs();
        tick();
    endtask

    // Both ports read continuously: grants alternate, tag FIFO saturates at 4.
    task automatic test_rr_reads();
        logic [1:0] exp_g;
        apply_reset();
        dma_pkt_i   = {PKT_RD1, PKT_RD0};
        dma_pkt_v_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            total_cnt++; if (dma_pkt_ready_and_o !== exp_g) $display("FAIL rr_grant%0d got %b want %b", i, dma_pkt_ready_and_o, exp_g); else pass_cnt++;
            total_cnt++; if (mem_pkt_o !== ((i % 2 == 0) ? PKT_RD0 : PKT_RD1)) $display("FAIL rr_pkt%0d got %h", i, mem_pkt_o); else pass_cnt++;
            total_cnt++; if (reads_pending_o !== 3'(i)) $display("FAIL rr_pending%0d got %0d want %0d", i, reads_pending_o, i); else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++; if (reads_pending_o !== 3'd4) $display("FAIL rr_full_pending got %0d want 4", reads_pending_o); else pass_cnt++;
        total_cnt++; if (mem_pkt_v_o !== 1'b0) $display("FAIL rr_full_stall got %b want 0", mem_pkt_v_o); else pass_cnt++;
        mem_data_v_i = 1'b1;
        for (int b = 0; b < 8; b++) begin
            mem_data_i = 64'(b);
            #1;
            total_cnt++; if (dma_data_v_o !== 2'b01) $display("FAIL rr_ret_v%0d got %b want 01", b, dma_data_v_o); else pass_cnt++;
            total_cnt++; if (dma_pkt_ready_and_o !== 2'b00) $display("FAIL rr_nobypass%0d got %b want 00", b, dma_pkt_ready_and_o); else pass_cnt++;
            tick();
        end
        mem_data_v_i = 1'b0;
        #1;
        total_cnt++; if (reads_pending_o !== 3'd3) $display("FAIL rr_after_pop got %0d want 3", reads_pending_o); else pass_cnt++;
        total_cnt++; if (dma_pkt_ready_and_o !== 2'b01) $display("FAIL rr_grant_after_pop got %b want 01", dma_pkt_ready_and_o); else pass_cnt++;
        tick();
        dma_pkt_v_i  = 2'b00;
        mem_data_v_i = 1'b1;
        #1;
        total_cnt++; if (reads_pending_o !== 3'd4) $display("FAIL rr_refill got %0d want 4", reads_pending_o); else pass_cnt++;
        total_cnt++; if (dma_data_v_o !== 2'b10) $display("FAIL rr_next_head got %b want 10", dma_data_v_o); else pass_cnt++;
        clear_inputs();
    endtask

    // Port 1 write with data 3 cycles late; a port 0 read waits for the 8th beat.
    task automatic test_write();
        logic [63:0] exp_d;
        apply_reset();
        dma_pkt_i   = {PKT_WR1, PKT_RD0};
        dma_pkt_v_i = 2'b10;
        #1;
        total_cnt++; if (mem_pkt_o !== PKT_WR1) $display("FAIL wr_pkt got %h want %h", mem_pkt_o, PKT_WR1); else pass_cnt++;
        total_cnt++; if (dma_pkt_ready_and_o !== 2'b10) $display("FAIL wr_grant got %b want 10", dma_pkt_ready_and_o); else pass_cnt++;
        tick();
        dma_pkt_v_i       = 2'b01;
        dma_data_i[63:0]  = 64'hDEAD_BEEF_DEAD_BEEF;
        dma_data_v_i      = 2'b01;
        for (int d = 0; d < 3; d++) begin
            #1;
            total_cnt++; if (mem_data_v_o !== 1'b0) $display("FAIL wr_gap_v%0d got %b want 0", d, mem_data_v_o); else pass_cnt++;
            total_cnt++; if (mem_pkt_v_o !== 1'b0) $display("FAIL wr_gap_pkt%0d got %b want 0", d, mem_pkt_v_o); else pass_cnt++;
            total_cnt++; if (dma_data_ready_and_o !== 2'b10) $display("FAIL wr_gap_rdy%0d got %b want 10", d, dma_data_ready_and_o); else pass_cnt++;
            tick();
        end
        for (int b = 0; b < 8; b++) begin
            exp_d              = 64'hA5A5_0000_0000_0000 | 64'(b);
            dma_data_i[127:64] = exp_d;
            dma_data_v_i       = 2'b11;
            #1;
            total_cnt++; if (mem_data_o !== exp_d) $display("FAIL wr_data%0d got %h want %h", b, mem_data_o, exp_d); else pass_cnt++;
            total_cnt++; if (mem_data_v_o !== 1'b1) $display("FAIL wr_v%0d got %b want 1", b, mem_data_v_o); else pass_cnt++;
            total_cnt++; if (mem_pkt_v_o !== 1'b0) $display("FAIL wr_no_grant%0d got %b want 0", b, mem_pkt_v_o); else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++; if (mem_data_v_o !== 1'b0) $display("FAIL wr_end_v got %b want 0", mem_data_v_o); else pass_cnt++;
        total_cnt++; if (dma_data_ready_and_o !== 2'b00) $display("FAIL wr_end_rdy got %b want 00", dma_data_ready_and_o); else pass_cnt++;
        total_cnt++; if (dma_pkt_ready_and_o !== 2'b01) $display("FAIL wr_read_grant got %b want 01", dma_pkt_ready_and_o); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if (reads_pending_o !== 3'd1) $display("FAIL wr_read_pending got %0d want 1", reads_pending_o); else pass_cnt++;
        clear_inputs();
    endtask

    // Reads in order 1,0,1; 24 returned beats are steered per block.
    task automatic test_order();
        int          seq [3] = '{1, 0, 1};
        int          port;
        logic [63:0] exp_d;
        apply_reset();
        dma_pkt_i = {PKT_RD1, PKT_RD0};
        for (int i = 0; i < 3; i++) begin
            dma_pkt_v_i = 2'(1 << seq[i]);
            #1;
            total_cnt++; if (dma_pkt_ready_and_o !== dma_pkt_v_i) $display("FAIL ord_grant%0d got %b want %b", i, dma_pkt_ready_and_o, dma_pkt_v_i); else pass_cnt++;
            tick();
        end
        dma_pkt_v_i  = 2'b00;
        mem_data_v_i = 1'b1;
        for (int b = 0; b < 24; b++) begin
            port       = seq[b / 8];
            exp_d      = 64'hC0DE_0000_0000_0000 + 64'(b);
            mem_data_i = exp_d;
            #1;
            total_cnt++; if (dma_data_v_o !== 2'(1 << port)) $display("FAIL ord_v%0d got %b want port %0d", b, dma_data_v_o, port); else pass_cnt++;
            total_cnt++; if (reads_pending_o !== 3'(3 - b / 8)) $display("FAIL ord_pending%0d got %0d want %0d", b, reads_pending_o, 3 - b / 8); else pass_cnt++;
            total_cnt++; if (dma_data_o !== {exp_d, exp_d}) $display("FAIL ord_data%0d got %h", b, dma_data_o); else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++; if (reads_pending_o !== 3'd0) $display("FAIL ord_drained got %0d want 0", reads_pending_o); else pass_cnt++;
        total_cnt++; if (mem_data_ready_and_o !== 1'b0) $display("FAIL ord_empty_rdy got %b want 0", mem_data_ready_and_o); else pass_cnt++;
        total_cnt++; if (dma_data_v_o !== 2'b00) $display("FAIL ord_empty_v got %b want 00", dma_data_v_o); else pass_cnt++;
        clear_inputs();
    endtask

    // Port 0 ready toggles 1,0: upstream ready mirrors it, exactly 8 beats land.
    task automatic test_backpressure();
        int          accepted = 0;
        logic        rdy;
        logic [63:0] exp_d;
        apply_reset();
        dma_pkt_i   = {PKT_RD1, PKT_RD0};
        dma_pkt_v_i = 2'b01;
        tick();
        dma_pkt_v_i  = 2'b00;
        mem_data_v_i = 1'b1;
        for (int cyc = 0; cyc < 40 && accepted < 8; cyc++) begin
            rdy                  = (cyc % 2 == 0);
            dma_data_ready_and_i = {1'b1, rdy};
            exp_d                = 64'h0000_0000_0000_B000 + 64'(accepted);
            mem_data_i           = exp_d;
            #1;
            total_cnt++; if (mem_data_ready_and_o !== rdy) $display("FAIL bp_rdy%0d got %b want %b", cyc, mem_data_ready_and_o, rdy); else pass_cnt++;
            total_cnt++; if (dma_data_v_o !== 2'b01) $display("FAIL bp_v%0d got %b want 01", cyc, dma_data_v_o); else pass_cnt++;
            total_cnt++; if (reads_pending_o !== 3'd1) $display("FAIL bp_pending%0d got %0d want 1", cyc, reads_pending_o); else pass_cnt++;
            total_cnt++; if (dma_data_o[63:0] !== exp_d) $display("FAIL bp_data%0d got %h want %h", cyc, dma_data_o[63:0], exp_d); else pass_cnt++;
            if (rdy) accepted++;
            tick();
        end
        total_cnt++; if (accepted !== 8) $display("FAIL bp_timeout accepted %0d want 8", accepted); else pass_cnt++;
        #1;
        total_cnt++; if (reads_pending_o !== 3'd0) $display("FAIL bp_pop got %0d want 0", reads_pending_o); else pass_cnt++;
        total_cnt++; if (mem_data_ready_and_o !== 1'b0) $display("FAIL bp_empty_rdy got %b want 0", mem_data_ready_and_o); else pass_cnt++;
        clear_inputs();
    endtask

    // Pop and read grant in the same cycle at count 3; order stays 1,0,1.
    task automatic test_push_pop();
        int seq [3] = '{1, 0, 1};
        apply_reset();
        dma_pkt_i   = {PKT_RD1, PKT_RD0};
        dma_pkt_v_i = 2'b11;
        tick();
        tick();
        tick();
        dma_pkt_v_i = 2'b00;
        #1;
        total_cnt++; if (reads_pending_o !== 3'd3) $display("FAIL pp_fill got %0d want 3", reads_pending_o); else pass_cnt++;
        mem_data_v_i = 1'b1;
        for (int b = 0; b < 8; b++) begin
            dma_pkt_v_i = (b == 7) ? 2'b10 : 2'b00;
            #1;
            total_cnt++; if (dma_data_v_o !== 2'b01) $display("FAIL pp_head0_v%0d got %b want 01", b, dma_data_v_o); else pass_cnt++;
            if (b == 7) begin
                total_cnt++; if (dma_pkt_ready_and_o !== 2'b10) $display("FAIL pp_grant got %b want 10", dma_pkt_ready_and_o); else pass_cnt++;
            end
            tick();
        end
        dma_pkt_v_i = 2'b00;
        #1;
        total_cnt++; if (reads_pending_o !== 3'd3) $display("FAIL pp_count got %0d want 3", reads_pending_o); else pass_cnt++;
        for (int b = 0; b < 24; b++) begin
            #1;
            total_cnt++; if (dma_data_v_o !== 2'(1 << seq[b / 8])) $display("FAIL pp_order%0d got %b want port %0d", b, dma_data_v_o, seq[b / 8]); else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++; if (reads_pending_o !== 3'd0) $display("FAIL pp_drained got %0d want 0", reads_pending_o); else pass_cnt++;
        clear_inputs();
    endtask

    // Reset at write beat 4 discards the write, the pending read and the rr pointer.
    task automatic test_reset_mid();
        apply_reset();
        dma_pkt_i   = {PKT_RD1, PKT_WR0};
        dma_pkt_v_i = 2'b10;
        #1;
        total_cnt++; if (dma_pkt_ready_and_o !== 2'b10) $display("FAIL rm_read_grant got %b want 10", dma_pkt_ready_and_o); else pass_cnt++;
        tick();
        dma_pkt_v_i = 2'b01;
        #1;
        total_cnt++; if (dma_pkt_ready_and_o !== 2'b01) $display("FAIL rm_write_grant got %b want 01", dma_pkt_ready_and_o); else pass_cnt++;
        tick();
        dma_pkt_v_i  = 2'b00;
        dma_data_v_i = 2'b01;
        for (int b = 0; b < 4; b++) begin
            dma_data_i[63:0] = 64'(b);
            #1;
            total_cnt++; if (mem_data_v_o !== 1'b1) $display("FAIL rm_beat%0d got %b want 1", b, mem_data_v_o); else pass_cnt++;
            tick();
        end
        reset_i = 1'b1;
        #1;
        total_cnt++; if (mem_data_v_o !== 1'b0) $display("FAIL rm_in_reset_v got %b want 0", mem_data_v_o); else pass_cnt++;
        total_cnt++; if (dma_data_ready_and_o !== 2'b00) $display("FAIL rm_in_reset_rdy got %b want 00", dma_data_ready_and_o); else pass_cnt++;
        tick();
        reset_i     = 1'b0;
        dma_pkt_i   = {PKT_RD1, PKT_RD0};
        dma_pkt_v_i = 2'b11;
        #1;
        total_cnt++; if (mem_data_v_o !== 1'b0) $display("FAIL rm_after_v got %b want 0", mem_data_v_o); else pass_cnt++;
        total_cnt++; if (dma_data_ready_and_o !== 2'b00) $display("FAIL rm_after_rdy got %b want 00", dma_data_ready_and_o); else pass_cnt++;
        total_cnt++; if (reads_pending_o !== 3'd0) $display("FAIL rm_after_pending got %0d want 0", reads_pending_o); else pass_cnt++;
        total_cnt++; if (dma_pkt_ready_and_o !== 2'b01) $display("FAIL rm_rr_ptr got %b want 01", dma_pkt_ready_and_o); else pass_cnt++;
        tick();
        clear_inputs();
    endtask

    initial begin
        reset_i = 1'b1;
        clear_inputs();
        test_reset();
        test_rr_reads();
        test_write();
        test_order();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
